// File: rtl/i2s_frame_sequencer.sv
//==============================================================================
// Module   : i2s_frame_sequencer
// Purpose  : Per-frame gain/saturate controller between I2S rx and tx ports,
//            sharing one registered multiplier between left and right channels.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2s_frame_sequencer #(
    parameter int D_WIDTH    = 24,
    parameter int GAIN_WIDTH = 9,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  ws,
    input  logic [D_WIDTH-1:0]    l_data_rx,
    input  logic [D_WIDTH-1:0]    r_data_rx,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  bypass,
    input  logic                  mute,
    input  logic                  clr_flags,
    output logic [D_WIDTH-1:0]    l_data_tx,
    output logic [D_WIDTH-1:0]    r_data_tx,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  clip,
    output logic                  overrun
);

    localparam int c_PW = D_WIDTH + GAIN_WIDTH + 1;
    localparam logic [D_WIDTH-1:0] c_SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] c_SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAP    = 3'd1,
        S_MUL_L  = 3'd2,
        S_MUL_R  = 3'd3,
        S_SAT    = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                   r_ws_d;
    logic [D_WIDTH-1:0]     r_cap_l;
    logic [D_WIDTH-1:0]     r_cap_r;
    logic [GAIN_WIDTH-1:0]  r_gain;
    logic                   r_bypass;
    logic                   r_mute;
    logic [D_WIDTH-1:0]     r_mul_op;
    logic signed [c_PW-1:0] r_prod;
    logic [D_WIDTH-1:0]     r_hold_l;
    logic                   r_clip_l;

    logic                   w_edge;
    logic signed [c_PW-1:0] w_op_ext;
    logic signed [c_PW-1:0] w_gain_ext;
    logic signed [c_PW-1:0] w_product;
    logic signed [c_PW-1:0] w_shift;
    logic                   w_ovf_hi;
    logic                   w_ovf_lo;
    logic                   w_clamp;
    logic [D_WIDTH-1:0]     w_sat;
    logic                   w_commit;
    logic                   w_clip_set;
    logic                   w_ovr_set;

    assign w_edge = r_ws_d & ~ws;
    assign busy   = (r_state != S_IDLE);

    // Gain is unsigned, so it is zero-extended; the low c_PW bits of the
    // full-width product are the exact signed result.
    assign w_op_ext   = {{(c_PW-D_WIDTH){r_mul_op[D_WIDTH-1]}}, r_mul_op};
    assign w_gain_ext = {{(c_PW-GAIN_WIDTH){1'b0}}, r_gain};
    assign w_product  = w_op_ext * w_gain_ext;

    assign w_shift  = r_prod >>> FRAC_BITS;
    assign w_ovf_hi = ~w_shift[c_PW-1] &  (|w_shift[c_PW-2:D_WIDTH-1]);
    assign w_ovf_lo =  w_shift[c_PW-1] & ~(&w_shift[c_PW-2:D_WIDTH-1]);
    assign w_clamp  = w_ovf_hi | w_ovf_lo;
    assign w_sat    = w_ovf_hi ? c_SAT_MAX :
                      w_ovf_lo ? c_SAT_MIN : w_shift[D_WIDTH-1:0];

    assign w_commit   = (r_state == S_COMMIT);
    assign w_clip_set = w_commit & ~r_mute & ~r_bypass & (r_clip_l | w_clamp);
    assign w_ovr_set  = w_edge & (r_state != S_IDLE);

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_edge) w_next = S_CAP;
            S_CAP:    w_next = S_MUL_L;
            S_MUL_L:  w_next = S_MUL_R;
            S_MUL_R:  w_next = S_SAT;
            S_SAT:    w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_ws_d     <= 1'b0;
            r_cap_l    <= '0;
            r_cap_r    <= '0;
            r_gain     <= '0;
            r_bypass   <= 1'b0;
            r_mute     <= 1'b0;
            r_mul_op   <= '0;
            r_prod     <= '0;
            r_hold_l   <= '0;
            r_clip_l   <= 1'b0;
            l_data_tx  <= '0;
            r_data_tx  <= '0;
            frame_done <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_ws_d     <= ws;
            frame_done <= w_commit;
            clip       <= w_clip_set | (clip & ~clr_flags);
            overrun    <= w_ovr_set | (overrun & ~clr_flags);

            case (r_state)
                S_CAP: begin
                    r_cap_l  <= l_data_rx;
                    r_cap_r  <= r_data_rx;
                    r_gain   <= gain;
                    r_bypass <= bypass;
                    r_mute   <= mute;
                end
                S_MUL_L: begin
                    r_mul_op <= r_cap_l;
                end
                S_MUL_R: begin
                    r_prod   <= w_product;
                    r_mul_op <= r_cap_r;
                end
                S_SAT: begin
                    r_prod   <= w_product;
                    r_hold_l <= w_sat;
                    r_clip_l <= w_clamp;
                end
                S_COMMIT: begin
                    // Mute outranks bypass; both skip the multiplier result.
                    if (r_mute) begin
                        l_data_tx <= '0;
                        r_data_tx <= '0;
                    end else if (r_bypass) begin
                        l_data_tx <= r_cap_l;
                        r_data_tx <= r_cap_r;
                    end else begin
                        l_data_tx <= r_hold_l;
                        r_data_tx <= w_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_sequencer.sv
//==============================================================================
// Module   : tb_i2s_frame_sequencer
// Purpose  : Scoreboard bench for i2s_frame_sequencer gain, modes and flags.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2s_frame_sequencer;

    logic        mclk = 1'b0;
    logic        reset;
    logic        ws;
    logic [23:0] l_data_rx;
    logic [23:0] r_data_rx;
    logic [8:0]  gain;
    logic        bypass;
    logic        mute;
    logic        clr_flags;
    logic [23:0] l_data_tx;
    logic [23:0] r_data_tx;
    logic        frame_done;
    logic        busy;
    logic        clip;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          due;
    } exp_t;

    exp_t sb[$];

    i2s_frame_sequencer dut (
        .mclk       (mclk),
        .reset      (reset),
        .ws         (ws),
        .l_data_rx  (l_data_rx),
        .r_data_rx  (r_data_rx),
        .gain       (gain),
        .bypass     (bypass),
        .mute       (mute),
        .clr_flags  (clr_flags),
        .l_data_tx  (l_data_tx),
        .r_data_tx  (r_data_tx),
        .frame_done (frame_done),
        .busy       (busy),
        .clip       (clip),
        .overrun    (overrun)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    // Returns {clamped, value} for one channel.
    function automatic logic [24:0] model_ch(input logic [23:0] s, input logic [8:0] g,
                                             input logic byp, input logic mu);
        longint p;
        longint q;
        if (mu)  return 25'd0;
        if (byp) return {1'b0, s};
        p = longint'($signed(s)) * longint'(g);
        q = p >>> 8;
        if (q > 64'sd8388607)  return {1'b1, 24'h7FFFFF};
        if (q < -64'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, q[23:0]};
    endfunction

    always @(negedge mclk) begin : monitor
        exp_t e;
        if (frame_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done: got frame_done=1 at cycle %0d, required no frame pending", cyc);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (l_data_tx !== e.l) begin
                    errors++;
                    $display("FAIL l_data_tx: got %h, required %h", l_data_tx, e.l);
                end
                if (r_data_tx !== e.r) begin
                    errors++;
                    $display("FAIL r_data_tx: got %h, required %h", r_data_tx, e.r);
                end
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL latency: frame_done at cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic start_frame(input logic [23:0] l, input logic [23:0] r, input logic [8:0] g,
                               input logic byp, input logic mu, output logic exp_clip);
        logic [24:0] ml;
        logic [24:0] mr;
        @(negedge mclk);
        l_data_rx = l;
        r_data_rx = r;
        gain      = g;
        bypass    = byp;
        mute      = mu;
        ws        = 1'b1;
        @(negedge mclk);
        ws = 1'b0;
        ml = model_ch(l, g, byp, mu);
        mr = model_ch(r, g, byp, mu);
        exp_clip = ml[24] | mr[24];
        sb.push_back('{l: ml[23:0], r: mr[23:0], due: cyc + 6});
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge mclk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_clr();
        @(negedge mclk);
        clr_flags = 1'b1;
        @(negedge mclk);
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ws = 1'b0; l_data_rx = '0; r_data_rx = '0;
        gain = 9'd256; bypass = 1'b0; mute = 1'b0; clr_flags = 1'b0;
        repeat (3) @(negedge mclk);
        checks++;
        if ({l_data_tx, r_data_tx, frame_done, busy, clip, overrun} !== 52'd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%h r=%h fd=%b busy=%b clip=%b ovr=%b, required all 0",
                     l_data_tx, r_data_tx, frame_done, busy, clip, overrun);
        end
        reset = 1'b0;
        repeat (2) @(negedge mclk);
    endtask

    task automatic test_unity();
        logic ec;
        int busy_cnt = 0;
        int fd_cnt = 0;
        start_frame(24'h123456, 24'hFEDCBA, 9'd256, 1'b0, 1'b0, ec);
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_cnt++;
            if (frame_done) fd_cnt++;
            @(negedge mclk);
        end
        wait_done();
        checks += 3;
        if (busy_cnt !== 5) begin
            errors++;
            $display("FAIL unity_busy_cycles: got %0d, required 5", busy_cnt);
        end
        if (fd_cnt !== 1) begin
            errors++;
            $display("FAIL unity_frame_done_count: got %0d, required 1", fd_cnt);
        end
        if (clip !== ec) begin
            errors++;
            $display("FAIL unity_clip: got %b, required %b", clip, ec);
        end
    endtask

    task automatic test_half_gain();
        logic ec;
        start_frame(24'h000100, 24'hFFFFFD, 9'd128, 1'b0, 1'b0, ec);
        wait_done();
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL half_clip: got %b, required 0", clip);
        end
    endtask

    task automatic test_saturation();
        logic ec;
        start_frame(24'h7FFFFF, 24'h800000, 9'd511, 1'b0, 1'b0, ec);
        wait_done();
        checks++;
        if (clip !== ec || ec !== 1'b1) begin
            errors++;
            $display("FAIL sat_clip: got %b, required 1", clip);
        end
        pulse_clr();
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL clr_clip: got %b, required 0", clip);
        end
    endtask

    task automatic test_modes();
        logic ec;
        start_frame(24'h400000, 24'h7FFFFF, 9'd511, 1'b1, 1'b1, ec);
        wait_done();
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL mute_clip: got %b, required 0", clip);
        end
        start_frame(24'h400000, 24'h876543, 9'd0, 1'b1, 1'b0, ec);
        wait_done();
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL bypass_clip: got %b, required 0", clip);
        end
        // Gain moves after capture; the frame must keep the old gain.
        start_frame(24'h000100, 24'h000200, 9'd256, 1'b0, 1'b0, ec);
        @(negedge mclk);
        @(negedge mclk);
        gain = 9'd64;
        wait_done();
        gain = 9'd256;
    endtask

    task automatic test_overrun();
        logic ec;
        int fd_cnt = 0;
        pulse_clr();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b, required 0", overrun);
        end
        start_frame(24'h0A0B0C, 24'h0D0E0F, 9'd256, 1'b0, 1'b0, ec);
        @(negedge mclk);
        ws = 1'b1;
        @(negedge mclk);
        ws = 1'b0;
        l_data_rx = 24'h555555;
        r_data_rx = 24'hAAAAAA;
        for (int i = 0; i < 15; i++) begin
            if (frame_done) fd_cnt++;
            @(negedge mclk);
        end
        wait_done();
        checks += 2;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        if (fd_cnt !== 1) begin
            errors++;
            $display("FAIL overrun_frame_done_count: got %0d, required 1", fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic ec;
        int act = 0;
        start_frame(24'h111111, 24'h222222, 9'd256, 1'b0, 1'b0, ec);
        repeat (3) @(negedge mclk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge mclk);
        sb.delete();
        checks++;
        if ({l_data_tx, r_data_tx, frame_done, busy, clip, overrun} !== 52'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got l=%h r=%h fd=%b busy=%b clip=%b ovr=%b, required all 0",
                     l_data_tx, r_data_tx, frame_done, busy, clip, overrun);
        end
        @(negedge mclk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            if (busy || frame_done) act++;
        end
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d active cycles, required 0", act);
        end
        start_frame(24'h0FEDCB, 24'hF01234, 9'd256, 1'b0, 1'b0, ec);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_unity();
        test_half_gain();
        test_saturation();
        test_modes();
        test_overrun();
        test_reset_mid();
        repeat (3) @(negedge mclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
- Per-frame processing controller between the I2S transceiver's receive and transmit data ports, running in the master clock domain.
- On each new stereo frame (word-select falling edge) it captures the received left/right samples and latches the frame's configuration.
- It time-shares one registered multiplier between the two channels to apply gain, saturates the results, then commits both transmit words together.
- It replaces the direct rx→tx loopback and reports saturation and overrun through sticky status flags.

Parameters:
- d_width, 24, sample width in bits (two's complement).
- gain_width, 9, unsigned gain width, format Q1.8 (256 = unity, 511 ≈ 1.996).
- frac_bits, 8, number of fractional gain bits removed after the multiply.

Ports:
- mclk  in  1  master clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ws  in  1  word select from the transceiver, already synchronous to mclk.
- l_data_rx  in  d_width  left sample received.
- r_data_rx  in  d_width  right sample received.
- gain  in  gain_width  unsigned Q1.8 gain.
- bypass  in  1  pass samples through unchanged.
- mute  in  1  force both outputs to zero; overrides bypass.
- clr_flags  in  1  single-cycle pulse that clears clip and overrun.
- l_data_tx  out  d_width  left sample to transmit.
- r_data_tx  out  d_width  right sample to transmit.
- frame_done  out  1  one-cycle pulse when the tx words update.
- busy  out  1  high while the FSM is not in IDLE.
- clip  out  1  sticky: saturation occurred.
- overrun  out  1  sticky: a frame edge arrived while busy.

Behaviour:
- Reset: all outputs 0; FSM state IDLE; ws_d = 0; capture and product registers 0.
- Frame edge detect: ws_d registers ws every cycle. An edge exists in a cycle where ws_d = 1 and ws = 0. Because ws_d resets to 0, a ws already low at reset gives no edge.
- States: IDLE → CAP → MUL_L → MUL_R → SAT → COMMIT → IDLE.
  - IDLE: on an edge, go to CAP.
  - CAP: latch l_data_rx, r_data_rx, gain, bypass and mute into frame registers.
  - MUL_L: left sample into the multiplier.
  - MUL_R: right sample into the multiplier; left product registered.
  - SAT: right product registered; left result shifted and saturated into a hold register.
  - COMMIT: right result shifted and saturated; l_data_tx and r_data_tx load on the same edge; frame_done = 1 for exactly one cycle.
- Latency: tx words and frame_done change 5 mclk cycles after the detection edge. A nominal frame (256 mclk) therefore leaves ample margin.
- Configuration: gain, bypass and mute are sampled only in CAP. Changes mid-sequence take effect next frame.
- Arithmetic:
  - Product = signed sample × {1'b0, gain}, width d_width+gain_width+1.
  - Arithmetic shift right by frac_bits (floor toward −inf).
  - Clamp to [−2^(d_width−1), 2^(d_width−1)−1].
  - Any clamp on either channel sets clip in COMMIT.
- Mode rules: mute → both outputs 0, no clip. Bypass (mute = 0) → outputs equal the captured samples, multiplier ignored, no clip.
- Overrun: an edge detected in any state other than IDLE sets overrun. That edge is dropped; the current sequence completes unchanged.
- Flags: clip and overrun stay set until clr_flags or reset. If clr_flags and a set event occur in the same cycle, set wins.
- busy = (state ≠ IDLE).
- Reset mid-sequence: abort at once. Outputs return to 0 and no frame_done is issued for the aborted frame.
- tx outputs hold their last committed values between commits.

Test Plan:
- Unity gain: gain=256, l=0x123456, r=0xFEDCBA, ws 1→0 → l_tx=0x123456, r_tx=0xFEDCBA exactly 5 cycles after detection; frame_done high 1 cycle; busy high 5 cycles.
- Half gain: gain=128, l=0x000100, r=0xFFFFFD (−3) → l_tx=0x000080, r_tx=0xFFFFFE (−2, floor); clip=0.
- Saturation: gain=511, l=0x7FFFFF, r=0x800000 → l_tx=0x7FFFFF, r_tx=0x800000, clip=1. Pulse clr_flags → clip=0.
- Modes:
  - mute=1 with bypass=1, l=0x400000 → both tx 0, clip=0.
  - bypass=1 with gain=0, l=0x400000 → l_tx=0x400000.
  - gain changed 2 cycles after the edge → current frame still uses the old gain.
- Overrun: second ws 1→0 edge 2 cycles after the first → overrun=1, single frame_done, outputs reflect the first frame's capture only.
- Reset: assert reset during MUL_R → all outputs 0, busy 0, no frame_done. Release with ws held low → no activity. Then ws 1→0 → normal commit.
